// File: rtl/ttl_pkg.sv
// Shared widths, event record and logger FSM encoding for the TTL event logger.
package ttl_pkg;

  localparam int TTL_W        = 32;
  localparam int TS_W         = 64;
  localparam int FIFO_DEPTH_D = 16;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [TTL_W-1:0] value;
  } ttl_evt_t;

  typedef enum logic [1:0] {
    LOG_IDLE = 2'd0,
    LOG_ARM  = 2'd1,
    LOG_RUN  = 2'd2
  } log_state_t;

endpackage

// File: rtl/ttl_evt_fifo.sv
// First-word-fall-through event FIFO: head is the oldest entry, zero when empty.
module ttl_evt_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ttl_event_logger.sv
// Drives masked TTL pins and logs every change of the TTL word as {timestamp, value}.
// Optional TTL_LOG_OVF_COUNT_EN adds a saturating dropped-event counter (ovf_count).
module ttl_event_logger
  import ttl_pkg::*;
#(
  parameter int TTL_WIDTH  = TTL_W,
  parameter int TS_WIDTH   = TS_W,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [TTL_WIDTH-1:0]          ttl_in,
  input  logic [TTL_WIDTH-1:0]          ttl_oe_mask,
  output logic [TTL_WIDTH-1:0]          ttl_pin,
  input  logic                          log_enable,
  input  logic                          ts_clear,
  output logic [TS_WIDTH+TTL_WIDTH-1:0] m_evt_tdata,
  output logic                          m_evt_tvalid,
  input  logic                          m_evt_tready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          evt_overflow,
`ifdef TTL_LOG_OVF_COUNT_EN
  output logic [15:0]                   ovf_count,
`endif
  input  logic                          overflow_clear,
  output logic [1:0]                    log_state
);

  logic [TS_WIDTH-1:0]  timestamp;
  logic [TTL_WIDTH-1:0] ttl_prev;
  logic                 change;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  log_state_t           state;
  log_state_t           state_next;

  assign change    = (ttl_in != ttl_prev);
  assign log_state = state;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ttl_pin   <= '0;
      ttl_prev  <= '0;
      timestamp <= '0;
      state     <= LOG_IDLE;
    end else begin
      ttl_pin   <= ttl_in & ttl_oe_mask;
      ttl_prev  <= ttl_in;
      timestamp <= ts_clear ? '0 : timestamp + 1'b1;
      state     <= state_next;
    end
  end

  // ARM takes one snapshot so software knows the pattern in force when logging began.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      LOG_IDLE: if (log_enable) state_next = LOG_ARM;
      LOG_ARM: begin
        push       = 1'b1;
        state_next = LOG_RUN;
      end
      LOG_RUN: begin
        push = change;
        if (!log_enable) state_next = LOG_IDLE;
      end
      default: state_next = LOG_IDLE;
    endcase
  end

  // Stream handshake: an event transfers on any cycle with m_evt_tvalid && m_evt_tready;
  // tvalid never waits on tready and tdata holds while tvalid && !tready.
  assign m_evt_tvalid = !empty;
  assign pop          = m_evt_tvalid && m_evt_tready;
  assign drop         = push && full && !pop;

  ttl_evt_fifo #(
    .WIDTH(TS_WIDTH + TTL_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .push     (push),
    .push_data({timestamp, ttl_in}),
    .pop      (pop),
    .head     (m_evt_tdata),
    .full     (full),
    .empty    (empty),
    .count    (evt_count)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)      evt_overflow <= 1'b0;
    else if (drop)           evt_overflow <= 1'b1;
    else if (overflow_clear) evt_overflow <= 1'b0;
  end

`ifdef TTL_LOG_OVF_COUNT_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                   ovf_count <= '0;
    else if (overflow_clear)              ovf_count <= drop ? 16'd1 : 16'd0;
    else if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1'b1;
  end
`else
  // Without the counter, drops are reported only through the sticky evt_overflow.
`endif

endmodule

// File: tb/tb_ttl_event_logger.sv
// Directed bench for ttl_event_logger: pin table, logging sequences, overflow and async reset.
module tb_ttl_event_logger;
  import ttl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ttl_in = '0;
  logic [31:0] ttl_oe_mask = '0;
  logic [31:0] ttl_pin;
  logic        log_enable = 1'b0;
  logic        ts_clear = 1'b0;
  logic [95:0] m_evt_tdata;
  logic        m_evt_tvalid;
  logic        m_evt_tready = 1'b0;
  logic [4:0]  evt_count;
  logic        evt_overflow;
  logic        overflow_clear = 1'b0;
  logic [1:0]  log_state;
`ifdef TTL_LOG_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [95:0] exp_q[$];
  logic [63:0] ts_model = '0;

  ttl_event_logger dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .ttl_in        (ttl_in),
    .ttl_oe_mask   (ttl_oe_mask),
    .ttl_pin       (ttl_pin),
    .log_enable    (log_enable),
    .ts_clear      (ts_clear),
    .m_evt_tdata   (m_evt_tdata),
    .m_evt_tvalid  (m_evt_tvalid),
    .m_evt_tready  (m_evt_tready),
    .evt_count     (evt_count),
    .evt_overflow  (evt_overflow),
`ifdef TTL_LOG_OVF_COUNT_EN
    .ovf_count     (ovf_count),
`endif
    .overflow_clear(overflow_clear),
    .log_state     (log_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // cycle timestamp as the block should see it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ts_model <= '0;
    else if (ts_clear) ts_model <= '0;
    else               ts_model <= ts_model + 64'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] evt(input logic [63:0] ts, input logic [31:0] v);
    ttl_evt_t e;
    e.ts    = ts;
    e.value = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Pops everything in the FIFO, comparing each accepted head with the scoreboard.
  task automatic drain(input int max_cyc);
    int n;
    logic [95:0] e;
    n = 0;
    m_evt_tready = 1'b1;
    while (m_evt_tvalid && n < max_cyc) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drain_extra: got %0h expected no event", m_evt_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("drain_data", m_evt_tdata, e);
      end
      step();
      n++;
    end
    m_evt_tready = 1'b0;
    chk("drain_tvalid", m_evt_tvalid, 0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] mask;
    logic [31:0] exp_pin;
  } pin_vec_t;

  pin_vec_t pin_tbl[5];

  initial begin
    pin_tbl[0] = '{32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0000_A5A5};
    pin_tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    pin_tbl[2] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    pin_tbl[3] = '{32'hDEAD_BEEF, 32'hF0F0_F0F0, 32'hD0A0_B0E0};
    pin_tbl[4] = '{32'h0F0F_0F0F, 32'hFF00_FF00, 32'h0F00_0F00};

    // reset state
    #7;
    chk("rst_pin", ttl_pin, 0);
    chk("rst_tvalid", m_evt_tvalid, 0);
    chk("rst_tdata", m_evt_tdata, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ovf", evt_overflow, 0);
    chk("rst_state", log_state, LOG_IDLE);
    #2;
    rst_n = 1'b1;
    step();

    // pin path, logging idle
    for (int i = 0; i < 5; i++) begin
      ttl_in      = pin_tbl[i].din;
      ttl_oe_mask = pin_tbl[i].mask;
      step();
      chk($sformatf("pin_%0d", i), ttl_pin, pin_tbl[i].exp_pin);
    end
    chk("idle_no_push", evt_count, 0);

    // snapshot at ts=10, change at ts=20
    ttl_in = 32'h0;
    do_reset();
    ttl_in = 32'h1;
    for (int i = 0; i < 50 && ts_model != 64'd9; i++) step();
    chk("t2_ts9", ts_model, 9);
    log_enable = 1'b1;
    step();
    chk("t2_arm", log_state, LOG_ARM);
    step();
    chk("t2_run", log_state, LOG_RUN);
    chk("t2_cnt1", evt_count, 1);
    chk("t2_tvalid", m_evt_tvalid, 1);
    chk("t2_snap", m_evt_tdata, evt(64'd10, 32'h1));
    for (int i = 0; i < 50 && ts_model != 64'd20; i++) step();
    ttl_in = 32'h3;
    step(2);
    chk("t2_cnt2", evt_count, 2);
    step(3);
    chk("t2_steady", evt_count, 2);
    exp_q.push_back(evt(64'd10, 32'h1));
    exp_q.push_back(evt(64'd20, 32'h3));
    drain(8);

    // 17 changes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      ttl_in = 32'h100 + i;
      if (i < 16) exp_q.push_back(evt(ts_model, ttl_in));
      step();
    end
    step();
    chk("t3_full", evt_count, 16);
    chk("t3_ovf", evt_overflow, 1);
`ifdef TTL_LOG_OVF_COUNT_EN
    chk("t3_ovf_cnt", ovf_count, 1);
`endif
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    chk("t3_ovf_clr", evt_overflow, 0);
`ifdef TTL_LOG_OVF_COUNT_EN
    chk("t3_ovf_cnt_clr", ovf_count, 0);
`endif

    // full FIFO: pop and push in the same cycle
    chk("t4_head_before", m_evt_tdata, exp_q[0]);
    m_evt_tready = 1'b1;
    ttl_in = 32'h200;
    exp_q.delete(0);
    exp_q.push_back(evt(ts_model, 32'h200));
    step();
    m_evt_tready = 1'b0;
    chk("t4_cnt", evt_count, 16);
    chk("t4_no_ovf", evt_overflow, 0);
    chk("t4_head_after", m_evt_tdata, exp_q[0]);
    step(2);
    chk("t4_hold", m_evt_tdata, exp_q[0]);
    drain(20);

    // ts_clear mid-run, then disable with a change in the same cycle
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
    ttl_in = 32'h300;
    exp_q.push_back(evt(64'd0, 32'h300));
    step();
    chk("t5_cnt", evt_count, 1);
    chk("t5_ts0", m_evt_tdata, evt(64'd0, 32'h300));
    log_enable = 1'b0;
    ttl_in = 32'h301;
    exp_q.push_back(evt(64'd1, 32'h301));
    step();
    chk("t5_idle", log_state, LOG_IDLE);
    ttl_in = 32'h302;
    step();
    ttl_in = 32'h303;
    step(2);
    chk("t5_no_push", evt_count, 2);
    drain(8);

    // async reset with five queued events
    log_enable = 1'b1;
    ttl_in = 32'h400;
    step();
    exp_q.push_back(evt(ts_model, 32'h400));
    step();
    for (int i = 1; i <= 4; i++) begin
      ttl_in = 32'h400 + i;
      exp_q.push_back(evt(ts_model, ttl_in));
      step();
    end
    step();
    chk("t6_cnt5", evt_count, 5);
    chk("t6_tvalid", m_evt_tvalid, 1);
    chk("t6_head", m_evt_tdata, exp_q[0]);
    rst_n = 1'b0;
    #1;
    chk("t6_async_tvalid", m_evt_tvalid, 0);
    chk("t6_async_cnt", evt_count, 0);
    chk("t6_async_tdata", m_evt_tdata, 0);
    chk("t6_async_pin", ttl_pin, 0);
    chk("t6_async_state", log_state, LOG_IDLE);
    exp_q.delete();
    log_enable = 1'b0;
    #2;
    rst_n = 1'b1;
    step(2);
    chk("t6_post_cnt", evt_count, 0);
    chk("t6_post_tvalid", m_evt_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
